// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES-128 key expansion, one round per clock, into an 11-entry
// round-key file with a registered read port.
module aes_key_sched_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic         rd_en,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key,
    output logic         rd_valid
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t         r_state;
    logic           r_ready, r_busy, r_done, r_keys_valid, r_rd_valid;
    logic [127:0]   r_rk [0:10];
    logic [127:0]   r_cur, r_rd_key;
    logic [3:0]     r_rnd;
    logic [79:0]    w_rsh;
    logic [7:0]     w_rcon;
    logic [31:0]    w_rot, w_tmp, w_n0, w_n1, w_n2, w_n3;
    logic [127:0]   w_nxt;
    logic           w_rd_ok;

    // Byte b lives at SBOX[8*(255-b) +: 8], and 255-b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    assign w_rsh  = RCON >> {4'd10 - r_rnd, 3'b000};
    assign w_rcon = w_rsh[7:0];
    assign w_rot  = {r_cur[23:0], r_cur[31:24]};
    assign w_tmp  = {sbox(w_rot[31:24]) ^ w_rcon, sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    assign w_n0   = r_cur[127:96] ^ w_tmp;
    assign w_n1   = r_cur[95:64] ^ w_n0;
    assign w_n2   = r_cur[63:32] ^ w_n1;
    assign w_n3   = r_cur[31:0] ^ w_n2;
    assign w_nxt  = {w_n0, w_n1, w_n2, w_n3};
    assign w_rd_ok = rd_en & r_keys_valid & (rd_addr <= 4'd10);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_key     <= '0;
            r_cur        <= '0;
            r_rnd        <= '0;
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= w_rd_ok;
            r_rd_key   <= w_rd_ok ? r_rk[rd_addr] : '0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_rk[0]      <= key_in;
                    r_cur        <= key_in;
                    r_rnd        <= 4'd1;
                    r_keys_valid <= 1'b0;
                    r_state      <= EXPAND;
                    r_ready      <= 1'b0;
                    r_busy       <= 1'b1;
                end
            end else begin
                r_rk[r_rnd] <= w_nxt;
                r_cur       <= w_nxt;
                if (r_rnd == 4'd10) begin
                    r_done       <= 1'b1;
                    r_keys_valid <= 1'b1;
                    r_state      <= IDLE;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                end else begin
                    r_rnd <= r_rnd + 4'd1;
                end
            end
        end
    end

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_keys_valid;
    assign rd_valid   = r_rd_valid;
    assign rd_key     = r_rd_key;
endmodule
